// File: rtl/serial_adder_pkg.sv
// Shared state encoding and bit-level helpers for the serial adder/subtractor family.
// The subtractor blocks reuse the same state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder: operands and start in, status and result out.
interface serial_adder_if #(parameter int unsigned WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder used as the per-bit step of the serial adder.
module full_adder_cell
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: sum = a + b + cin, one bit per clock, LSB first.
// Operands are captured on an accepted start; sum/cout hold until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic             last;

    full_adder_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));
    // Shift-in written with shifts rather than a slice so WIDTH=1 elaborates.
    assign s_next = (s_sh >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    carry <= bit_c;
                    s_sh  <= s_next;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum_q  <= s_next;
                        cout_q <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1, plus a subtract/add round trip.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one 8-bit op; return edges from start edge to done, and the result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output logic [7:0] sum, output logic cout);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        sum = bus8.sum;
        cout = bus8.cout;
    endtask

    task automatic run1(input logic a, input logic b, input logic cin,
                        output int lat, output logic sum, output logic cout);
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 0;
        while (!bus1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sum = bus1.sum;
        cout = bus1.cout;
    endtask

    initial begin
        int lat;
        int ndone;
        logic [7:0] s8;
        logic c8;
        logic s1;
        logic c1;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] tt;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(bus8.busy), 32'd0);
        check("reset_done", 32'(bus8.done), 32'd0);
        check("reset_sum", 32'(bus8.sum), 32'd0);
        check("reset_cout", 32'(bus8.cout), 32'd0);

        // 5 + 3, including busy/done status during the shift and after completion
        bus8.a = 8'd5; bus8.b = 8'd3; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("shift_busy", 32'(bus8.busy), 32'd1);
        check("shift_done", 32'(bus8.done), 32'd0);
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat_5p3", 32'(lat), 32'd8);
        check("sum_5p3", 32'(bus8.sum), 32'd8);
        check("cout_5p3", 32'(bus8.cout), 32'd0);
        check("done_busy", 32'(bus8.busy), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(bus8.done), 32'd0);
        check("idle_busy", 32'(bus8.busy), 32'd0);
        check("sum_held", 32'(bus8.sum), 32'd8);

        run8(8'hFF, 8'h01, 1'b0, lat, s8, c8);
        check("sum_ff01", 32'(s8), 32'h00);
        check("cout_ff01", 32'(c8), 32'd1);
        @(negedge clk);
        run8(8'h00, 8'h00, 1'b1, lat, s8, c8);
        check("sum_cin", 32'(s8), 32'h01);
        check("cout_cin", 32'(c8), 32'd0);
        check("lat_cin", 32'(lat), 32'd8);
        @(negedge clk);

        // start held high; operands change mid-op; second op takes operands at acceptance
        bus8.a = 8'd10; bus8.b = 8'd20; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        bus8.a = 8'h77; bus8.b = 8'h11;
        ndone = 0;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hold_sum", 32'(bus8.sum), 32'd30);
        check("hold_cout", 32'(bus8.cout), 32'd0);
        @(negedge clk);
        check("hold_idle_busy", 32'(bus8.busy), 32'd0);
        check("hold_idle_done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        check("hold_second_accept", 32'(bus8.busy), 32'd1);
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("second_sum", 32'(bus8.sum), 32'h88);
        @(negedge clk);

        // reset during the 4th SHIFT cycle aborts with no done pulse
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_sum", 32'(bus8.sum), 32'd0);
        check("abort_cout", 32'(bus8.cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run8(8'd1, 8'd1, 1'b0, lat, s8, c8);
        check("after_abort_sum", 32'(s8), 32'd2);
        @(negedge clk);

        // rst and start on the same edge: start dropped
        rst = 1'b1; bus8.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus8.start = 1'b0;
        check("rst_wins_busy", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        check("rst_wins_idle", 32'(bus8.busy), 32'd0);

        // WIDTH=1 exhaustive truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            tt = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
            run1(vv[2], vv[1], vv[0], lat, s1, c1);
            check("w1_lat", 32'(lat), 32'd1);
            check("w1_sum_cout", 32'({c1, s1}), 32'(tt));
            @(negedge clk);
        end

        // subtract/add round trip
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra - rb, rb, 1'b0, lat, s8, c8);
            check("roundtrip", 32'(s8), 32'(ra));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
